// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer sharing one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_opcode,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_opcode,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [OP_W-1:0]  alu_opcode,
  output logic [WIDTH-1:0] alu_data_A,
  output logic [WIDTH-1:0] alu_data_B,
  input  logic [WIDTH-1:0] alu_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             idle, accept, gnt;
  // ties go to the requester not served last; nothing is offered while reset is high
  assign idle       = (state_q == IDLE) && !reset;
  assign req0_ready = idle && req0_valid && (!req1_valid || last_grant_q);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant_q);
  assign accept     = req0_ready || req1_ready;
  assign gnt        = req1_ready;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign alu_opcode  = alu_op_q;
  assign alu_data_A  = alu_a_q;
  assign alu_data_B  = alu_b_q;
  // next state: latch operands on accept, capture result in EXEC, release on response handshake
  always_comb begin
    state_d       = accept ? EXEC :
                    (state_q == EXEC) ? RESP :
                    (state_q == RESP && resp_ready) ? IDLE : state_q;
    alu_op_d      = accept ? (gnt ? req1_opcode : req0_opcode) : alu_op_q;
    alu_a_d       = accept ? (gnt ? req1_A : req0_A) : alu_a_q;
    alu_b_d       = accept ? (gnt ? req1_B : req0_B) : alu_b_q;
    resp_id_d     = accept ? gnt : resp_id_q;
    last_grant_d  = accept ? gnt : last_grant_q;
    resp_result_d = (state_q == EXEC) ? alu_result : resp_result_q;
    resp_valid_d  = (state_q == EXEC) ? 1'b1 :
                    (state_q == RESP && resp_ready) ? 1'b0 : resp_valid_q;
  end
  // state registers; reset discards any in-flight operation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenario bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
  logic        clock, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode, alu_opcode;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result, alu_data_A, alu_data_B, alu_result;
  int total = 0;
  int bad = 0;

  alu_share_arbiter #(.WIDTH(32), .OP_W(5)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_A(req1_A), .req1_B(req1_B),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .alu_opcode(alu_opcode),
    .alu_data_A(alu_data_A), .alu_data_B(alu_data_B), .alu_result(alu_result)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a << b[4:0];
      5'd5: return a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_opcode, alu_data_A, alu_data_B);

  // one clock; requesters drop valid after a completed handshake
  task automatic tick();
    logic r0, r1;
    @(negedge clock);
    r0 = req0_ready;
    r1 = req1_ready;
    @(posedge clock);
    #1;
    if (r0) req0_valid = 0;
    if (r1) req1_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    req0_valid = 0;
    req1_valid = 0;
    resp_ready = 0;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  task automatic drain(input int n, input string tag);
    int seen = 0;
    resp_ready = 1;
    for (int i = 0; i < 30 && seen < n; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    tick();
    total++;
    if (seen != n) begin bad++; $display("FAIL drain_%s seen=%0d want=%0d", tag, seen, n); end
  endtask

  task automatic test_reset();
    reset = 1;
    req0_valid = 1; req0_opcode = 0; req0_A = 1; req0_B = 1;
    req1_valid = 1; req1_opcode = 0; req1_A = 1; req1_B = 1;
    resp_ready = 1;
    #1;
    total++; if (req0_ready !== 0 || req1_ready !== 0) begin bad++; $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready); end
    tick();
    total++; if (resp_valid !== 0 || resp_id !== 0 || resp_result !== 0) begin bad++; $display("FAIL reset_resp got=%b %b %h want=0 0 0", resp_valid, resp_id, resp_result); end
    total++; if (alu_opcode !== 0 || alu_data_A !== 0 || alu_data_B !== 0) begin bad++; $display("FAIL reset_alu got=%h %h %h want=0 0 0", alu_opcode, alu_data_A, alu_data_B); end
    req0_valid = 0;
    req1_valid = 0;
    reset = 0;
    #1;
  endtask

  task automatic test_single_and();
    req0_opcode = 5'b00010; req0_A = 32'hF0F0F0F0; req0_B = 32'hFF00FF00; req0_valid = 1;
    resp_ready = 1;
    #1;
    total++; if (req0_ready !== 1) begin bad++; $display("FAIL and_ready got=%b want=1", req0_ready); end
    tick();
    total++; if (alu_opcode !== 5'b00010 || alu_data_A !== 32'hF0F0F0F0 || alu_data_B !== 32'hFF00FF00) begin bad++; $display("FAIL and_alu_in got=%h %h %h", alu_opcode, alu_data_A, alu_data_B); end
    total++; if (resp_valid !== 0) begin bad++; $display("FAIL and_early_resp got=%b want=0", resp_valid); end
    tick();
    total++; if (resp_valid !== 1 || resp_id !== 0 || resp_result !== 32'hF000F000) begin bad++; $display("FAIL and_resp got=%b %b %h want=1 0 f000f000", resp_valid, resp_id, resp_result); end
    tick();
    total++; if (resp_valid !== 0) begin bad++; $display("FAIL and_done got=%b want=0", resp_valid); end
  endtask

  task automatic test_contention();
    reset = 1;
    resp_ready = 1;
    req0_opcode = 5'b00011; req0_A = 32'h0000FFFF; req0_B = 32'h00FF0000; req0_valid = 1;
    req1_opcode = 5'b00010; req1_A = 32'hFFFFFFFF; req1_B = 32'h12345678; req1_valid = 1;
    tick();
    reset = 0;
    #1;
    total++; if (req0_ready !== 1 || req1_ready !== 0) begin bad++; $display("FAIL cont_first_grant got=%b%b want=10", req0_ready, req1_ready); end
    tick();
    total++; if (req1_ready !== 0 || alu_opcode !== 5'b00011) begin bad++; $display("FAIL cont_exec got=%b %h want=0 03", req1_ready, alu_opcode); end
    tick();
    total++; if (resp_valid !== 1 || resp_id !== 0 || resp_result !== 32'h00FFFFFF) begin bad++; $display("FAIL cont_resp0 got=%b %b %h want=1 0 00ffffff", resp_valid, resp_id, resp_result); end
    tick();
    total++; if (req1_ready !== 1) begin bad++; $display("FAIL cont_grant1 got=%b want=1", req1_ready); end
    tick();
    tick();
    total++; if (resp_valid !== 1 || resp_id !== 1 || resp_result !== 32'h12345678) begin bad++; $display("FAIL cont_resp1 got=%b %b %h want=1 1 12345678", resp_valid, resp_id, resp_result); end
    tick();
    req0_valid = 1;
    req1_valid = 1;
    #1;
    total++; if (req0_ready !== 1 || req1_ready !== 0) begin bad++; $display("FAIL cont_reissue got=%b%b want=10", req0_ready, req1_ready); end
    drain(2, "contention");
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_opcode = 5'b00001; req0_A = 10; req0_B = 3; req0_valid = 1;
    req1_opcode = 5'b00011; req1_A = 32'hA0; req1_B = 32'h0B; req1_valid = 1;
    #1;
    total++; if (req0_ready !== 1) begin bad++; $display("FAIL bp_grant0 got=%b want=1", req0_ready); end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1 || resp_id !== 0 || resp_result !== 7) begin bad++; $display("FAIL bp_hold%0d got=%b %b %h want=1 0 7", i, resp_valid, resp_id, resp_result); end
      total++; if (req0_ready !== 0 || req1_ready !== 0) begin bad++; $display("FAIL bp_ready%0d got=%b%b want=00", i, req0_ready, req1_ready); end
      tick();
    end
    resp_ready = 1;
    tick();
    total++; if (resp_valid !== 0 || req1_ready !== 1) begin bad++; $display("FAIL bp_release got=%b %b want=0 1", resp_valid, req1_ready); end
    tick();
    total++; if (alu_opcode !== 5'b00011 || alu_data_A !== 32'hA0 || alu_data_B !== 32'h0B) begin bad++; $display("FAIL bp_req1_accept got=%h %h %h", alu_opcode, alu_data_A, alu_data_B); end
    drain(1, "backpressure");
  endtask

  task automatic test_fairness();
    int ids[8];
    int at[8];
    int n = 0;
    do_reset();
    resp_ready = 1;
    req0_opcode = 0; req0_A = 1; req0_B = 1; req0_valid = 1;
    req1_opcode = 0; req1_A = 2; req1_B = 2; req1_valid = 1;
    for (int i = 0; i < 40 && n < 8; i++) begin
      tick();
      req0_valid = 1;
      req1_valid = 1;
      if (resp_valid) begin ids[n] = int'(resp_id); at[n] = i; n++; end
    end
    req0_valid = 0;
    req1_valid = 0;
    tick();
    total++; if (n != 8) begin bad++; $display("FAIL rr_count got=%0d want=8", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (ids[i] != i % 2) begin bad++; $display("FAIL rr_id%0d got=%0d want=%0d", i, ids[i], i % 2); end
    end
    for (int i = 1; i < n; i++) begin
      total++; if (at[i] - at[i-1] != 3) begin bad++; $display("FAIL rr_gap%0d got=%0d want=3", i, at[i] - at[i-1]); end
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    resp_ready = 1;
    req0_opcode = 0; req0_A = 1; req0_B = 2; req0_valid = 1;
    tick();
    total++; if (alu_data_A !== 1 || alu_data_B !== 2) begin bad++; $display("FAIL rst_exec_in got=%h %h want=1 2", alu_data_A, alu_data_B); end
    reset = 1;
    req0_valid = 1;
    req1_valid = 1;
    req1_opcode = 0; req1_A = 4; req1_B = 4;
    #1;
    total++; if (resp_valid !== 0 || resp_result !== 0 || alu_opcode !== 0 || alu_data_A !== 0 || alu_data_B !== 0) begin bad++; $display("FAIL rst_clear got=%b %h %h %h %h want=all0", resp_valid, resp_result, alu_opcode, alu_data_A, alu_data_B); end
    total++; if (req0_ready !== 0 || req1_ready !== 0) begin bad++; $display("FAIL rst_ready got=%b%b want=00", req0_ready, req1_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (resp_valid !== 0) begin bad++; $display("FAIL rst_no_resp%0d got=%b want=0", i, resp_valid); end
    end
    reset = 0;
    #1;
    total++; if (req0_ready !== 1 || req1_ready !== 0) begin bad++; $display("FAIL rst_after_grant got=%b%b want=10", req0_ready, req1_ready); end
    drain(2, "reset");
  endtask

  task automatic test_unknown_opcode();
    resp_ready = 1;
    req0_opcode = 5'b11111; req0_A = 5; req0_B = 3; req0_valid = 1;
    #1;
    total++; if (req0_ready !== 1) begin bad++; $display("FAIL unk_ready got=%b want=1", req0_ready); end
    tick();
    total++; if (alu_opcode !== 5'b11111) begin bad++; $display("FAIL unk_opcode got=%b want=11111", alu_opcode); end
    tick();
    total++; if (resp_valid !== 1 || resp_result !== 6) begin bad++; $display("FAIL unk_result got=%b %h want=1 6", resp_valid, resp_result); end
    tick();
    total++; if (resp_valid !== 0) begin bad++; $display("FAIL unk_done got=%b want=0", resp_valid); end
    req0_opcode = 0; req0_valid = 1;
    #1;
    total++; if (req0_ready !== 1) begin bad++; $display("FAIL unk_idle got=%b want=1", req0_ready); end
    drain(1, "unknown");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_opcode = 0; req0_A = 0; req0_B = 0;
    req1_opcode = 0; req1_A = 0; req1_B = 0;
    test_reset();
    test_single_and();
    test_contention();
    test_backpressure();
    test_fairness();
    test_reset_mid_exec();
    test_unknown_opcode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and two-way arbiter that shares one 32-bit ALU datapath (add/sub/and/or/shift bit-slice logic) between two requesters. It accepts one operation at a time from either requester over a valid/ready handshake, registers the operands onto the shared ALU inputs, captures the ALU result one cycle later, and returns it tagged with the requester ID over a valid/ready response port. It sits between the instruction-side clients and the combinational ALU, so the ALU itself never sees contention.

## Interface
- WIDTH, 32, data width of operands and result
- OP_W, 5, opcode width; passed through to the ALU unchanged
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opcode  in  OP_W  requester 0 ALU opcode
- req0_A, req0_B  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_opcode, req1_A, req1_B: same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester the result belongs to
- resp_result  out  WIDTH  captured ALU result
- alu_opcode  out  OP_W  registered opcode to the shared ALU
- alu_data_A, alu_data_B  out  WIDTH  registered operands to the shared ALU
- alu_result  in  WIDTH  combinational ALU output

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: operands are on the ALU and the result is settling.
  - RESP: result is held until the consumer takes it.
- IDLE:
  - The grant goes to the single valid requester.
  - If both are valid, the grant goes to the requester not granted last (round-robin pointer last_grant).
  - Only the granted requester sees ready=1.
  - When the granted valid&ready handshake completes:
    - Latch opcode/A/B into alu_opcode/alu_data_A/alu_data_B.
    - Latch the requester ID.
    - Set last_grant to that ID.
    - Go to EXEC.
- EXEC: unconditionally capture alu_result into resp_result, set resp_valid=1, go to RESP.
- RESP:
  - Hold resp_valid, resp_id and resp_result stable.
  - On resp_valid&resp_ready, clear resp_valid and go to IDLE.
- Both reqN_ready signals are 0 in EXEC and RESP. At most one operation is in flight at any time.
- Opcode is not decoded or checked. Unknown opcodes pass through, and whatever the ALU returns is the result.
- The alu_* registers hold their last values outside an accept; they are not cleared after use.
- Requesters must hold valid and payload stable until ready. The block never drops a pending request.

## Timing
- Reset (async, immediate), with the FSM in IDLE:
  - last_grant=1, so requester 0 wins the first tie.
  - resp_valid=0, resp_id=0, resp_result=0.
  - alu_opcode=0, alu_data_A=0, alu_data_B=0.
  - req0_ready=req1_ready=0 while reset is high.
- reqN_ready is combinational from state, last_grant and both valids. It is 1 only in IDLE.
- Latency:
  - Accept edge at cycle T.
  - ALU inputs are valid from T through T+1.
  - resp_valid=1 from edge T+1.
  - With resp_ready held at 1, the response completes at edge T+2 and IDLE is reached.
  - The next accept is possible at edge T+3.
  - Peak throughput is one operation per 3 cycles.
- Simultaneous valids: the loser's ready stays 0. After the winner's response completes, the loser is granted in the next IDLE, so strict alternation holds under continuous contention.
- resp_ready is ignored outside RESP.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is produced, and reset values apply.

## Test plan
- Single AND:
  - Stimulus: req0 opcode=00010, A=0xF0F0F0F0, B=0xFF00FF00, resp_ready=1.
  - Required: req0_ready=1 at accept edge T; resp_valid=1, resp_id=0, resp_result=0xF000F000 after edge T+1; back in IDLE after edge T+2.
- Contention:
  - Stimulus: req0 and req1 both valid from reset release, with req0 OR (00011, 0x0000FFFF, 0x00FF0000) and req1 AND (00010, 0xFFFFFFFF, 0x12345678).
  - Required: first response id=0, result=0x00FFFFFF; second response id=1, result=0x12345678.
  - Required: a re-issued pair next serves req0 first again, since last_grant=1 at that point.
- Backpressure:
  - Stimulus: resp_ready held at 0 for 5 cycles in RESP while req1 is valid.
  - Required: resp_valid, resp_id and resp_result stay stable; req0_ready=req1_ready=0 throughout; req1 is accepted in the first IDLE cycle after resp_ready=1.
- Round-robin fairness:
  - Stimulus: both requesters held continuously valid for 8 operations.
  - Required: resp_id sequence is 0,1,0,1,0,1,0,1; responses are spaced exactly 3 cycles apart with resp_ready=1.
- Reset mid-EXEC:
  - Stimulus: assert reset in the cycle after accepting req0 ADD (00000, 1, 2).
  - Required: resp_valid never rises; all outputs read 0 immediately.
  - Required after reset release: a simultaneous req0/req1 pair grants req0 first.
- Unknown opcode:
  - Stimulus: opcode=11111 with A=5, B=3.
  - Required: alu_opcode=11111 during EXEC; resp_result equals the bench ALU model's output for that opcode; the FSM returns to IDLE normally.
